// File: rtl/ro_uart_logger.sv
// Captures every new value of the processor's Ro register into a small FIFO and sends each one as an 8N1 UART frame on tx.
// Optional macro RO_UART_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module ro_uart_logger #(
    parameter int bits         = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [bits-1:0]               Ro,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] RELOAD_C = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef RO_UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [bits-1:0] prev_ro_q;
    logic            primed_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, ovf_q;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
`ifdef RO_UART_PARITY_EN
    logic            par_q, par_d;
`endif

    logic       capture_s, pop_s, push_s;
    logic [7:0] ro_ext_s, head_s;

    assign ro_ext_s  = 8'(Ro);
    assign head_s    = mem_q[rd_ptr_q];
    assign capture_s = (Ro != prev_ro_q) || !primed_q;
    // A pop can only happen from IDLE with data already stored, which frees a slot for this edge's capture.
    assign pop_s     = (state_q == S_IDLE) && (count_q != {CW{1'b0}});
    assign push_s    = capture_s && ((count_q != DEPTH_C) || pop_s);

    // FIFO occupancy next state
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Transmit FSM next state and the line value that goes with it
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - BW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
`ifdef RO_UART_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    shift_d = head_s;
                    cnt_d   = RELOAD_C;
                    state_d = S_START;
`ifdef RO_UART_PARITY_EN
                    par_d   = ^head_s;
`endif
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            S_START: begin
                if (cnt_q == {BW{1'b0}}) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = RELOAD_C;
                end else begin
                    state_d   = S_START;
                end
            end
            S_DATA: begin
                if (cnt_q == {BW{1'b0}}) begin
                    cnt_d   = RELOAD_C;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef RO_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef RO_UART_PARITY_EN
            S_PARITY: begin
                if (cnt_q == {BW{1'b0}}) begin
                    state_d = S_STOP;
                    cnt_d   = RELOAD_C;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == {BW{1'b0}}) begin
                    state_d = S_IDLE;
                    cnt_d   = RELOAD_C;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = RELOAD_C;
            end
        endcase

        // tx is registered, so it is derived from the state being entered.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef RO_UART_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // FIFO storage; contents need no reset because pointers guard every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= ro_ext_s;
        end
    end

    // Capture tracking, FIFO bookkeeping and transmitter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ro_q <= {bits{1'b0}};
            primed_q  <= 1'b0;
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {CW{1'b0}};
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= RELOAD_C;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
`ifdef RO_UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            prev_ro_q <= Ro;
            primed_q  <= 1'b1;
            wr_ptr_q  <= push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q  <= pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q   <= count_d;
            full_q    <= (count_d == DEPTH_C);
            ovf_q     <= ovf_q | (capture_s & ~push_s);
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef RO_UART_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign fifo_full  = full_q;
    assign overflow   = ovf_q;
endmodule
